dc_miss_responder: RTL and testbench
====================================

// Module: dc_miss_responder
// PURPOSE
//  MMU-side responder for the data-cache miss/evict and uncached-IO interfaces.
//  Services dirty-line writebacks (dc_evict), line fills (dc_miss) and PCD IO reads/writes.
//  Converts each request into BEAT_W-wide handshaked beats on the main-memory bus.
//  Returns fill data with a one-cycle dc_miss_ack, or IO data with a one-cycle io_ack.
// PARAMETERS
//  LINE_W  128  cache line width in bits (must equal BEATS*BEAT_W)
//  BEAT_W  32   memory bus data width in bits
//  BEATS   4    beats per line; beat counter width = clog2(BEATS)
// PORTS
//  clk            in   1       clock, all state updates on rising edge
//  rst            in   1       synchronous reset, active-high
//  dc_miss        in   1       line fill request, level, held until dc_miss_ack
//  dc_miss_addr   in   32      line-aligned fill address ([3:0]=0)
//  dc_evict       in   1       dirty writeback required, qualified by dc_miss
//  dc_evict_addr  in   32      line-aligned victim address
//  dc_evict_data  in   LINE_W  victim line data
//  dc_data_fill   out  LINE_W  assembled fill line, valid while dc_miss_ack=1
//  dc_miss_ack    out  1       one-cycle pulse, miss (and evict) complete
//  io_access      in   1       uncached access request, level, held until io_ack
//  io_rw          in   1       1=write, 0=read
//  io_addr        in   32      word-aligned IO address
//  io_wr_data     in   32      IO write data
//  io_rd_data     out  32      IO read data, valid with io_ack, held until next IO read
//  io_ack         out  1       one-cycle pulse, IO access complete
//  mem_req        out  1       memory beat request
//  mem_we         out  1       1=write beat
//  mem_addr       out  32      beat byte address
//  mem_wdata      out  BEAT_W  write beat data
//  mem_rdata      in   BEAT_W  read beat data, valid with mem_ack
//  mem_ack        in   1       beat complete; ignored when mem_req=0
//  busy           out  1       1 in any state other than IDLE
// BEHAVIOUR
//  - States: IDLE, EVICT, FILL, MACK, IO, IACK, GUARD.
//  - IDLE: dc_miss has priority over io_access. dc_miss&dc_evict -> EVICT; dc_miss alone -> FILL;
//    else io_access -> IO. On acceptance, latch addresses, dc_evict_data, io_rw/io_wr_data; beat cnt=0.
//  - Beat i: mem_addr=base+4*i, data slice [BEAT_W*i +: BEAT_W]. mem_req/we/addr/wdata stable
//    until mem_ack; on mem_ack cnt++ and next beat issues the following cycle without a gap (mem_req stays 1).
//  - EVICT: BEATS write beats from latched victim data; after last ack -> FILL, cnt=0.
//  - FILL: BEATS read beats, mem_rdata stored in fill buffer slice i; after last ack -> MACK.
//  - MACK: dc_miss_ack=1 for exactly one cycle, dc_data_fill=fill buffer; -> GUARD.
//  - IO: one beat, mem_we=io_rw, mem_addr=io_addr; on read, io_rd_data<=mem_rdata; -> IACK.
//  - IACK: io_ack=1 one cycle; -> GUARD.
//  - GUARD: one cycle ignoring requests (cache deasserts level request after ack); -> IDLE.
//  - Zero-wait memory latency: miss, no evict, request seen in IDLE at T: beats T+1..T+4,
//    dc_miss_ack T+5, IDLE T+7. Dirty miss: evict T+1..T+4, fill T+5..T+8, ack T+9.
//  - Wait states: each beat stretches one cycle per cycle without mem_ack; no timeout.
//  - Request inputs changing after acceptance are ignored; the latched copy is used.
//  - Reset (any state): state=IDLE, cnt=0, all outputs 0 (incl. dc_data_fill, io_rd_data),
//    buffers cleared; an in-flight beat is abandoned.
//  - dc_data_fill holds last fill value outside MACK (no clearing except reset).
// TESTING
//  1 Clean miss 0x0000_1A40, mem returns 0x11,0x22,0x33,0x44 zero-wait -> reads 0x1A40..0x1A4C,
//    dc_miss_ack at T+5 with dc_data_fill=0x00000044_00000033_00000022_00000011.
//  2 Dirty miss, victim 0x0000_0A40 data 128'hDDDD..AAAA -> 4 writes to 0x0A40.. then 4 reads
//    of fill address, ack at T+9 only.
//  3 IO read 0x0000_F004 with 3 wait cycles, mem_rdata 0xCAFEF00D -> io_ack once,
//    io_rd_data=0xCAFEF00D, mem_req held 4 cycles.
//  4 dc_miss and io_access raised same cycle -> miss fully served first; io served after GUARD.
//  5 rst asserted mid-FILL beat 2 -> next cycle all outputs 0, busy=0; new miss served from beat 0.
//  6 dc_miss held 1 cycle past dc_miss_ack -> no second fill issued (GUARD).

Source files
------------

// File: rtl/dc_miss_responder_if.sv
// Cache-side miss/evict/IO request signals and main-memory beat bus for dc_miss_responder.
// master = the responder itself, slave = the cache/memory environment facing it.
interface dc_miss_responder_if #(
    parameter int LINE_W = 128,
    parameter int BEAT_W = 32
);
    logic              dc_miss;
    logic [31:0]       dc_miss_addr;
    logic              dc_evict;
    logic [31:0]       dc_evict_addr;
    logic [LINE_W-1:0] dc_evict_data;
    logic [LINE_W-1:0] dc_data_fill;
    logic              dc_miss_ack;
    logic              io_access;
    logic              io_rw;
    logic [31:0]       io_addr;
    logic [31:0]       io_wr_data;
    logic [31:0]       io_rd_data;
    logic              io_ack;
    logic              mem_req;
    logic              mem_we;
    logic [31:0]       mem_addr;
    logic [BEAT_W-1:0] mem_wdata;
    logic [BEAT_W-1:0] mem_rdata;
    logic              mem_ack;
    logic              busy;

    modport master (
        input  dc_miss, dc_miss_addr, dc_evict, dc_evict_addr, dc_evict_data,
        input  io_access, io_rw, io_addr, io_wr_data,
        input  mem_rdata, mem_ack,
        output dc_data_fill, dc_miss_ack, io_rd_data, io_ack,
        output mem_req, mem_we, mem_addr, mem_wdata, busy
    );

    modport slave (
        output dc_miss, dc_miss_addr, dc_evict, dc_evict_addr, dc_evict_data,
        output io_access, io_rw, io_addr, io_wr_data,
        output mem_rdata, mem_ack,
        input  dc_data_fill, dc_miss_ack, io_rd_data, io_ack,
        input  mem_req, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/dc_miss_responder.sv
// MMU-side responder: turns dirty-line writebacks, line fills and uncached IO accesses
// into handshaked BEAT_W-wide memory beats, returning fill/IO data with one-cycle acks.
module dc_miss_responder #(
    parameter int LINE_W = 128,
    parameter int BEAT_W = 32,
    parameter int BEATS  = 4
) (
    input  logic clk,
    input  logic rst,
    dc_miss_responder_if.master bus
);
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [2:0] {IDLE, EVICT, FILL, MACK, IO, IACK, GUARD} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [31:0]       miss_addr_q, evict_addr_q, io_addr_q, io_wr_data_q;
    logic              io_rw_q;
    logic [LINE_W-1:0] evict_data_q, fill_buf, fill_merged, data_fill_q;
    logic [31:0]       io_rd_data_q;
    logic              last_beat;
    logic [31:0]       beat_off;
    logic              mem_req, mem_we;
    logic [31:0]       mem_addr;
    logic [BEAT_W-1:0] mem_wdata;

    assign last_beat = (cnt == CNT_W'(BEATS - 1));
    assign beat_off  = 32'(cnt) << 2;

    always_comb begin
        state_nxt   = state;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        // fill buffer with the beat currently on mem_rdata merged in, so the
        // completed line can be published on the same edge as the last ack
        fill_merged = fill_buf;
        fill_merged[BEAT_W*int'(cnt) +: BEAT_W] = bus.mem_rdata;
        case (state)
            IDLE: begin
                if (bus.dc_miss)
                    state_nxt = bus.dc_evict ? EVICT : FILL;
                else if (bus.io_access)
                    state_nxt = IO;
            end
            EVICT: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = evict_addr_q + beat_off;
                mem_wdata = evict_data_q[BEAT_W*int'(cnt) +: BEAT_W];
                if (bus.mem_ack && last_beat)
                    state_nxt = FILL;
            end
            FILL: begin
                mem_req  = 1'b1;
                mem_addr = miss_addr_q + beat_off;
                if (bus.mem_ack && last_beat)
                    state_nxt = MACK;
            end
            MACK:  state_nxt = GUARD;
            IO: begin
                mem_req   = 1'b1;
                mem_we    = io_rw_q;
                mem_addr  = io_addr_q;
                mem_wdata = io_rw_q ? BEAT_W'(io_wr_data_q) : '0;
                if (bus.mem_ack)
                    state_nxt = IACK;
            end
            IACK:  state_nxt = GUARD;
            GUARD: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            miss_addr_q  <= '0;
            evict_addr_q <= '0;
            evict_data_q <= '0;
            io_rw_q      <= 1'b0;
            io_addr_q    <= '0;
            io_wr_data_q <= '0;
            fill_buf     <= '0;
            data_fill_q  <= '0;
            io_rd_data_q <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (bus.dc_miss) begin
                        miss_addr_q  <= bus.dc_miss_addr;
                        evict_addr_q <= bus.dc_evict_addr;
                        evict_data_q <= bus.dc_evict_data;
                    end else if (bus.io_access) begin
                        io_rw_q      <= bus.io_rw;
                        io_addr_q    <= bus.io_addr;
                        io_wr_data_q <= bus.io_wr_data;
                    end
                end
                EVICT: begin
                    if (bus.mem_ack)
                        cnt <= last_beat ? '0 : cnt + 1'b1;
                end
                FILL: begin
                    if (bus.mem_ack) begin
                        fill_buf <= fill_merged;
                        cnt      <= last_beat ? '0 : cnt + 1'b1;
                        if (last_beat)
                            data_fill_q <= fill_merged;
                    end
                end
                IO: begin
                    if (bus.mem_ack && !io_rw_q)
                        io_rd_data_q <= 32'(bus.mem_rdata);
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_req      = mem_req;
    assign bus.mem_we       = mem_we;
    assign bus.mem_addr     = mem_addr;
    assign bus.mem_wdata    = mem_wdata;
    assign bus.dc_miss_ack  = (state == MACK);
    assign bus.dc_data_fill = data_fill_q;
    assign bus.io_ack       = (state == IACK);
    assign bus.io_rd_data   = io_rd_data_q;
    assign bus.busy         = (state != IDLE);
endmodule

// File: tb/tb_dc_miss_responder.sv
// Bench for dc_miss_responder: memory model with wait states, beat scoreboard,
// table-driven miss/IO transactions plus priority, guard and reset-mid-fill sequences.
module tb_dc_miss_responder;
    localparam int LINE_W = 128;
    localparam int BEAT_W = 32;
    localparam int BEATS  = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dc_miss_responder_if #(.LINE_W(LINE_W), .BEAT_W(BEAT_W)) bus();

    dc_miss_responder #(.LINE_W(LINE_W), .BEAT_W(BEAT_W), .BEATS(BEATS)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } beat_t;

    typedef struct {
        bit           is_io;
        bit           rw;
        bit           evict;
        logic [31:0]  addr;
        logic [31:0]  eaddr;
        logic [31:0]  wdata;
        logic [127:0] edata;
        logic [127:0] line;
        int           wait_cyc;
        logic [127:0] expv;
    } vec_t;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    beat_t       exp_beats[$];
    logic [31:0] rd_words[$];
    int mem_wait   = 0;
    int wcnt       = 0;
    int req_cycles = 0;
    int beats_done = 0;
    int miss_acks  = 0;
    int io_acks    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Memory model: acks a beat after mem_wait idle cycles and checks it against the scoreboard.
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = '0;
            wcnt = 0;
        end else if (bus.mem_req) begin
            req_cycles++;
            if (wcnt >= mem_wait) begin
                bus.mem_ack = 1'b1;
                wcnt = 0;
                beats_done++;
                if (exp_beats.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat: got we=%0b addr=%h, expected no beat",
                             bus.mem_we, bus.mem_addr);
                end else begin
                    e = exp_beats.pop_front();
                    check("beat_we", bus.mem_we, e.we);
                    check("beat_addr", bus.mem_addr, e.addr);
                    if (e.we) check("beat_wdata", bus.mem_wdata, e.wdata);
                end
                if (!bus.mem_we)
                    bus.mem_rdata = (rd_words.size() > 0) ? rd_words.pop_front() : 32'hBAD0_BAD0;
                else
                    bus.mem_rdata = $urandom;
            end else begin
                bus.mem_ack   = 1'b0;
                bus.mem_rdata = $urandom;
                wcnt++;
                if (exp_beats.size() > 0)
                    check("beat_addr_held", bus.mem_addr, exp_beats[0].addr);
            end
        end else begin
            bus.mem_ack = 1'b0;
            wcnt = 0;
        end
        if (bus.dc_miss_ack) miss_acks++;
        if (bus.io_ack) io_acks++;
    end

    task automatic push_miss(input logic [31:0] addr, input logic [127:0] line);
        for (int i = 0; i < BEATS; i++) begin
            exp_beats.push_back('{1'b0, addr + 32'(4 * i), 32'h0});
            rd_words.push_back(line[32*i +: 32]);
        end
    endtask

    task automatic run_txn(input vec_t v, input bit hold_extra);
        int k, nb, m0, i0, rc0, lim;
        logic [127:0] got;
        mem_wait = v.wait_cyc;
        nb = v.is_io ? 1 : (v.evict ? 2 * BEATS : BEATS);
        if (v.is_io) begin
            exp_beats.push_back('{v.rw, v.addr, v.rw ? v.wdata : 32'h0});
            if (!v.rw) rd_words.push_back(v.line[31:0]);
        end else begin
            if (v.evict)
                for (int i = 0; i < BEATS; i++)
                    exp_beats.push_back('{1'b1, v.eaddr + 32'(4 * i), v.edata[32*i +: 32]});
            push_miss(v.addr, v.line);
        end
        m0 = miss_acks; i0 = io_acks; rc0 = req_cycles;
        @(posedge clk); #1;
        k = cyc;
        if (v.is_io) begin
            bus.io_access = 1'b1; bus.io_rw = v.rw; bus.io_addr = v.addr; bus.io_wr_data = v.wdata;
        end else begin
            bus.dc_miss = 1'b1; bus.dc_miss_addr = v.addr; bus.dc_evict = v.evict;
            bus.dc_evict_addr = v.eaddr; bus.dc_evict_data = v.edata;
        end
        @(posedge clk); #1;
        // request fields change after acceptance; only the latched copy may be used
        bus.dc_miss_addr = ~v.addr; bus.dc_evict_addr = ~v.eaddr; bus.dc_evict_data = ~v.edata;
        bus.dc_evict = ~v.evict; bus.io_addr = ~v.addr; bus.io_wr_data = ~v.wdata; bus.io_rw = ~v.rw;
        for (lim = 0; lim < 300; lim++) begin
            @(negedge clk);
            if (v.is_io ? bus.io_ack : bus.dc_miss_ack) break;
        end
        check("ack_seen", lim < 300, 1'b1);
        got = v.is_io ? {96'h0, bus.io_rd_data} : bus.dc_data_fill;
        check("ack_data", got, v.expv);
        check("ack_cycle", cyc, k + 1 + nb * (v.wait_cyc + 1));
        @(posedge clk); #1;
        if (hold_extra) begin
            @(posedge clk); #1;
        end
        bus.dc_miss = 1'b0; bus.io_access = 1'b0;
        repeat (3) @(negedge clk);
        check("ack_count", v.is_io ? io_acks - i0 : miss_acks - m0, 1);
        check("req_cycles", req_cycles - rc0, nb * (v.wait_cyc + 1));
        check("beats_left", exp_beats.size(), 0);
        check("busy_after", bus.busy, 1'b0);
        got = v.is_io ? {96'h0, bus.io_rd_data} : bus.dc_data_fill;
        check("data_held", got, v.expv);
    endtask

    vec_t vt[6];
    vec_t hv;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int k, m0, i0, b0, lim, miss_cyc;
        vt[0] = '{0, 0, 0, 32'h0000_1A40, 32'h0, 32'h0, 128'h0,
                  128'h00000044_00000033_00000022_00000011, 0,
                  128'h00000044_00000033_00000022_00000011};
        vt[1] = '{0, 0, 1, 32'h0000_2C80, 32'h0000_0A40, 32'h0,
                  128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA,
                  128'h00000004_00000003_00000002_00000001, 0,
                  128'h00000004_00000003_00000002_00000001};
        vt[2] = '{1, 0, 0, 32'h0000_F004, 32'h0, 32'h0, 128'h0,
                  128'hCAFEF00D, 3, 128'hCAFEF00D};
        vt[3] = '{1, 1, 0, 32'h0000_F008, 32'h0, 32'h1234_5678, 128'h0,
                  128'h0, 1, 128'hCAFEF00D};
        vt[4] = '{0, 0, 0, 32'h0000_3000, 32'h0, 32'h0, 128'h0,
                  128'h89ABCDEF_01234567_FEDCBA98_76543210, 2,
                  128'h89ABCDEF_01234567_FEDCBA98_76543210};
        vt[5] = '{0, 0, 1, 32'h0000_07F0, 32'h0000_FFF0, 32'h0,
                  128'h0F0F0F0F_F0F0F0F0_55555555_AAAAAAAA,
                  128'h600D0003_600D0002_600D0001_600D0000, 1,
                  128'h600D0003_600D0002_600D0001_600D0000};

        rst = 1'b1;
        bus.dc_miss = 1'b0; bus.dc_miss_addr = '0; bus.dc_evict = 1'b0;
        bus.dc_evict_addr = '0; bus.dc_evict_data = '0;
        bus.io_access = 1'b0; bus.io_rw = 1'b0; bus.io_addr = '0; bus.io_wr_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_mem_req", bus.mem_req, 1'b0);
        check("rst_miss_ack", bus.dc_miss_ack, 1'b0);
        check("rst_io_ack", bus.io_ack, 1'b0);
        check("rst_fill", bus.dc_data_fill, 128'h0);
        check("rst_io_rd", bus.io_rd_data, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run_txn(vt[i], 1'b0);

        // Miss and IO raised together: miss completes first, IO follows after GUARD
        mem_wait = 0;
        push_miss(32'h0000_4000, 128'h44440000_33330000_22220000_11110000);
        exp_beats.push_back('{1'b0, 32'h0000_F100, 32'h0});
        rd_words.push_back(32'h5A5A_A5A5);
        i0 = io_acks;
        @(posedge clk); #1;
        k = cyc;
        bus.dc_miss = 1'b1; bus.dc_miss_addr = 32'h0000_4000; bus.dc_evict = 1'b0;
        bus.io_access = 1'b1; bus.io_rw = 1'b0; bus.io_addr = 32'h0000_F100;
        for (lim = 0; lim < 100; lim++) begin
            @(negedge clk);
            if (bus.dc_miss_ack) break;
        end
        miss_cyc = cyc;
        check("prio_miss_ack_cycle", miss_cyc, k + 5);
        check("prio_fill", bus.dc_data_fill, 128'h44440000_33330000_22220000_11110000);
        check("prio_io_not_yet", io_acks - i0, 0);
        @(posedge clk); #1;
        bus.dc_miss = 1'b0;
        for (lim = 0; lim < 100; lim++) begin
            @(negedge clk);
            if (bus.io_ack) break;
        end
        check("prio_io_ack_cycle", cyc, miss_cyc + 4);
        check("prio_io_data", bus.io_rd_data, 32'h5A5A_A5A5);
        @(posedge clk); #1;
        bus.io_access = 1'b0;
        repeat (3) @(negedge clk);
        check("prio_beats_left", exp_beats.size(), 0);

        // dc_miss held through GUARD must not start a second fill
        hv = '{0, 0, 0, 32'h0000_4A00, 32'h0, 32'h0, 128'h0,
               128'h0000000D_0000000C_0000000B_0000000A, 0,
               128'h0000000D_0000000C_0000000B_0000000A};
        run_txn(hv, 1'b1);

        // Reset while FILL beat 2 is waiting for mem_ack
        mem_wait = 3;
        push_miss(32'h0000_5000, 128'h0);
        b0 = beats_done;
        @(posedge clk); #1;
        bus.dc_miss = 1'b1; bus.dc_miss_addr = 32'h0000_5000; bus.dc_evict = 1'b0;
        for (lim = 0; lim < 100 && beats_done < b0 + 2; lim++) @(negedge clk);
        check("midfill_reached", beats_done - b0, 2);
        @(posedge clk); #1;
        check("midfill_beat2_addr", bus.mem_addr, 32'h0000_5008);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_mem_req", bus.mem_req, 1'b0);
        check("midrst_busy", bus.busy, 1'b0);
        check("midrst_mem_addr", bus.mem_addr, 32'h0);
        check("midrst_fill", bus.dc_data_fill, 128'h0);
        check("midrst_io_rd", bus.io_rd_data, 32'h0);
        check("midrst_miss_ack", bus.dc_miss_ack, 1'b0);
        bus.dc_miss = 1'b0;
        exp_beats.delete();
        rd_words.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        hv = '{0, 0, 0, 32'h0000_6000, 32'h0, 32'h0, 128'h0,
               128'hA0A0A0A3_A0A0A0A2_A0A0A0A1_A0A0A0A0, 0,
               128'hA0A0A0A3_A0A0A0A2_A0A0A0A1_A0A0A0A0};
        run_txn(hv, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
